// File: rtl/multicycle_datapath_pkg.sv
// Shared encodings for the multicycle RV32I core: opcodes, select-line enums
// and ALU operation codes used by both the datapath and the control unit.
package wjbot_riscv;

  typedef enum logic [6:0] {
    OP_NONE   = 7'b0000000,
    OP_LOAD   = 7'b0000011,
    OP_IMM    = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_REG    = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111
  } opcodetype_t;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_t;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_REG   = 2'b10,
    SRCA_RSVD  = 2'b11
  } alu_src_a_t;

  typedef enum logic [1:0] {
    SRCB_REG   = 2'b00,
    SRCB_IMM   = 2'b01,
    SRCB_FOUR  = 2'b10,
    SRCB_RSVD  = 2'b11
  } alu_src_b_t;

  typedef enum logic [1:0] {
    RES_ALUOUT = 2'b00,
    RES_DATA   = 2'b01,
    RES_ALU    = 2'b10,
    RES_RSVD   = 2'b11
  } result_src_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Sign-extended immediate for the selected instruction format.
  function automatic logic [31:0] imm_extend(input logic [31:0] instr,
                                             input imm_src_t    src);
    logic [31:0] imm;
    imm = '0;
    case (src)
      IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J: imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/multicycle_datapath_regfile.sv
// 32x32 register file, two combinational read ports, one write port, x0 = 0.
// DATAPATH_RF_RESET_EN: contents clear on reset; otherwise the array has no reset.
module regfile
  (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] mem_q [32];
  logic        wr_en;

  // A write coinciding with reset is dropped; x0 is never stored.
  assign wr_en = we && reset && (wa != 5'd0);

`ifdef DATAPATH_RF_RESET_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wa] <= wd;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wa] <= wd;
    end
  end
`endif

  // No write-to-read bypass: a same-cycle read returns the old contents.
  assign rd1 = (ra1 == 5'd0) ? 32'd0 : mem_q[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : mem_q[ra2];

endmodule

// File: rtl/multicycle_datapath.sv
// Datapath half of the multicycle RV32I core: PC/OldPC/Instr/Data/A/B/ALUOut,
// register file, immediate extender and ALU. Register-file reset via DATAPATH_RF_RESET_EN.
module multicycle_datapath
  import wjbot_riscv::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  ImmSrc,
  input  logic [1:0]  ALUSrcA,
  input  logic [1:0]  ALUSrcB,
  input  logic [1:0]  ResultSrc,
  input  logic        AdrSrc,
  input  logic [2:0]  ALUControl,
  input  logic        IRWrite,
  input  logic        PCWrite,
  input  logic        RegWrite,
  input  logic [31:0] ReadData,
  output logic [31:0] Adr,
  output logic [31:0] WriteData,
  output opcodetype_t op,
  output logic [2:0]  funct3,
  output logic        funct7b5,
  output logic        Zero
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] oldpc_q, oldpc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] data_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] aluout_q;

  logic [31:0] rf_rd1, rf_rd2;
  logic [31:0] imm_ext;
  logic [31:0] src_a, src_b;
  logic [31:0] alu_result;
  logic [31:0] result;

  regfile u_regfile (
    .clk   (clk),
    .reset (reset),
    .ra1   (instr_q[19:15]),
    .ra2   (instr_q[24:20]),
    .we    (RegWrite),
    .wa    (instr_q[11:7]),
    .wd    (result),
    .rd1   (rf_rd1),
    .rd2   (rf_rd2)
  );

  assign imm_ext = imm_extend(instr_q, imm_src_t'(ImmSrc));

  always_comb begin
    src_a = '0;
    case (alu_src_a_t'(ALUSrcA))
      SRCA_PC:    src_a = pc_q;
      SRCA_OLDPC: src_a = oldpc_q;
      SRCA_REG:   src_a = a_q;
      default:    src_a = '0;
    endcase
  end

  always_comb begin
    src_b = '0;
    case (alu_src_b_t'(ALUSrcB))
      SRCB_REG:  src_b = b_q;
      SRCB_IMM:  src_b = imm_ext;
      SRCB_FOUR: src_b = 32'd4;
      default:   src_b = '0;
    endcase
  end

  always_comb begin
    alu_result = '0;
    case (ALUControl)
      ALU_ADD: alu_result = src_a + src_b;
      ALU_SUB: alu_result = src_a - src_b;
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_SLT: alu_result = {31'd0, ($signed(src_a) < $signed(src_b))};
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    result = '0;
    case (result_src_t'(ResultSrc))
      RES_ALUOUT: result = aluout_q;
      RES_DATA:   result = data_q;
      RES_ALU:    result = alu_result;
      default:    result = '0;
    endcase
  end

  // Enabled registers; OldPC samples the PC as it stands before this edge.
  always_comb begin
    pc_d    = PCWrite ? result : pc_q;
    oldpc_d = IRWrite ? pc_q : oldpc_q;
    instr_d = IRWrite ? ReadData : instr_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      oldpc_q  <= '0;
      instr_q  <= '0;
      data_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
    end else begin
      pc_q     <= pc_d;
      oldpc_q  <= oldpc_d;
      instr_q  <= instr_d;
      data_q   <= ReadData;
      a_q      <= rf_rd1;
      b_q      <= rf_rd2;
      aluout_q <= alu_result;
    end
  end

  assign Adr       = AdrSrc ? result : pc_q;
  assign WriteData = b_q;
  assign Zero      = (alu_result == 32'd0);
  assign op        = opcodetype_t'(instr_q[6:0]);
  assign funct3    = instr_q[14:12];
  assign funct7b5  = instr_q[30];

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath: the driver issues control vectors and
// queues the expected output; a negedge monitor pops and compares.
module tb_multicycle_datapath;
  import wjbot_riscv::*;

  localparam int W = 32;
  localparam int K_ADR  = 0;
  localparam int K_WD   = 1;
  localparam int K_OP   = 2;
  localparam int K_F3   = 3;
  localparam int K_F7   = 4;
  localparam int K_ZERO = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  ImmSrc, ALUSrcA, ALUSrcB, ResultSrc;
  logic        AdrSrc;
  logic [2:0]  ALUControl;
  logic        IRWrite, PCWrite, RegWrite;
  logic [31:0] ReadData;
  logic [31:0] Adr, WriteData;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5, Zero;

  logic [W-1:0] exp_q[$];
  int           kind_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] mon_exp, mon_act;
  int           mon_kind;

  multicycle_datapath #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .ImmSrc     (ImmSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .AdrSrc     (AdrSrc),
    .ALUControl (ALUControl),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .RegWrite   (RegWrite),
    .ReadData   (ReadData),
    .Adr        (Adr),
    .WriteData  (WriteData),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero)
  );

  // Clock
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  function automatic string kname(input int k);
    case (k)
      K_ADR:   return "Adr";
      K_WD:    return "WriteData";
      K_OP:    return "op";
      K_F3:    return "funct3";
      K_F7:    return "funct7b5";
      default: return "Zero";
    endcase
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_exp  = exp_q.pop_front();
      mon_kind = kind_q.pop_front();
      case (mon_kind)
        K_ADR:   mon_act = Adr;
        K_WD:    mon_act = WriteData;
        K_OP:    mon_act = {25'd0, op};
        K_F3:    mon_act = {29'd0, funct3};
        K_F7:    mon_act = {31'd0, funct7b5};
        default: mon_act = {31'd0, Zero};
      endcase
      checks++;
      if (mon_act !== mon_exp) begin
        errors++;
        $display("FAIL %s #%0d: got %h expected %h at %0t",
                 kname(mon_kind), checks, mon_act, mon_exp, $time);
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int kind, input logic [W-1:0] v);
    exp_q.push_back(v);
    kind_q.push_back(kind);
  endtask

  task automatic idle();
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    RegWrite = 1'b0;
  endtask

  // Route ALUResult to Adr so any operand combination can be observed.
  task automatic view_alu(input logic [1:0] sa, input logic [1:0] sb,
                          input logic [2:0] ac, input logic [1:0] is);
    idle();
    ALUSrcA    = sa;
    ALUSrcB    = sb;
    ALUControl = ac;
    ImmSrc     = is;
    ResultSrc  = 2'b10;
    AdrSrc     = 1'b1;
  endtask

  task automatic fetch(input logic [31:0] instr, input logic [31:0] pc);
    ReadData   = instr;
    IRWrite    = 1'b1;
    PCWrite    = 1'b1;
    RegWrite   = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b10;
    ALUControl = 3'b000;
    ResultSrc  = 2'b10;
    chk(K_ADR, pc);
    tick();
    idle();
    chk(K_ADR, pc + 32'd4);
    chk(K_OP, {25'd0, instr[6:0]});
    chk(K_F3, {29'd0, instr[14:12]});
    chk(K_F7, {31'd0, instr[30]});
    tick();
  endtask

  task automatic exec_addi(input logic [31:0] v);
    view_alu(2'b10, 2'b01, 3'b000, 2'b00);
    chk(K_ADR, v);
    tick();
    ResultSrc = 2'b00;
    RegWrite  = 1'b1;
    chk(K_ADR, v);
    tick();
    RegWrite  = 1'b0;
  endtask

  initial begin
    reset      = 1'b0;
    ImmSrc     = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    AdrSrc     = 1'b0;
    ALUControl = 3'b000;
    ReadData   = 32'd0;
    idle();
    tick();
    tick();
    reset = 1'b1;
    checks++;
    if (Adr !== 32'd0) begin
      errors++;
      $display("FAIL Adr after reset: got %h expected %h at %0t", Adr, 32'd0, $time);
    end
    checks++;
    if (op !== 7'd0) begin
      errors++;
      $display("FAIL op after reset: got %h expected %h at %0t", op, 7'd0, $time);
    end
    chk(K_ADR, 32'd0);
    chk(K_OP, 32'd0);
    chk(K_F3, 32'd0);
    chk(K_F7, 32'd0);
    chk(K_WD, 32'd0);
    chk(K_ZERO, 32'd1);
    tick();

    // addi x1,x0,5 then addi x2,x1,0
    fetch(32'h0050_0093, 32'd0);
    exec_addi(32'd5);
    fetch(32'h0000_8113, 32'd4);
    view_alu(2'b01, 2'b11, 3'b000, 2'b00);
    chk(K_ADR, 32'd4);
    tick();
    exec_addi(32'd5);

    // beq x1,x2,8 with x1 == x2
    fetch(32'h0020_8463, 32'd8);
    view_alu(2'b10, 2'b00, 3'b001, 2'b00);
    chk(K_ZERO, 32'd1);
    chk(K_ADR, 32'd0);
    chk(K_WD, 32'd5);
    tick();
    view_alu(2'b01, 2'b01, 3'b000, 2'b10);
    chk(K_ADR, 32'd16);
    tick();

    // addi x2,x0,2: rd == rs2, so B shows the no-bypass behaviour
    fetch(32'h0020_0113, 32'd12);
    view_alu(2'b10, 2'b01, 3'b000, 2'b00);
    chk(K_ADR, 32'd2);
    chk(K_WD, 32'd5);
    tick();
    ResultSrc = 2'b00;
    RegWrite  = 1'b1;
    chk(K_ADR, 32'd2);
    chk(K_WD, 32'd5);
    tick();
    RegWrite  = 1'b0;
    chk(K_WD, 32'd5);
    tick();
    chk(K_WD, 32'd2);
    tick();

    // x2 = 6, then beq x1,x2 again and the logic/compare ops on 5 and 6
    fetch(32'h0060_0113, 32'd16);
    exec_addi(32'd6);
    fetch(32'h0020_8463, 32'd20);
    view_alu(2'b10, 2'b00, 3'b001, 2'b00);
    chk(K_ZERO, 32'd0);
    chk(K_ADR, 32'hFFFF_FFFF);
    tick();
    view_alu(2'b10, 2'b00, 3'b101, 2'b00);
    chk(K_ADR, 32'd1);
    tick();
    view_alu(2'b10, 2'b00, 3'b010, 2'b00);
    chk(K_ADR, 32'd4);
    tick();
    view_alu(2'b10, 2'b00, 3'b011, 2'b00);
    chk(K_ADR, 32'd7);
    tick();
    view_alu(2'b10, 2'b00, 3'b111, 2'b00);
    chk(K_ADR, 32'd0);
    chk(K_ZERO, 32'd1);
    tick();

    // jal x1,-4: J/I/S immediates against OldPC=24, signed slt
    fetch(32'hFFDF_F0EF, 32'd24);
    view_alu(2'b01, 2'b01, 3'b000, 2'b11);
    chk(K_ADR, 32'd20);
    tick();
    view_alu(2'b01, 2'b01, 3'b101, 2'b11);
    chk(K_ADR, 32'd0);
    tick();
    view_alu(2'b01, 2'b01, 3'b000, 2'b00);
    chk(K_ADR, 32'd21);
    tick();
    view_alu(2'b01, 2'b01, 3'b000, 2'b01);
    chk(K_ADR, 32'hFFFF_FFF9);
    tick();

    // sw x1,8(x0)
    fetch(32'h0010_2423, 32'd28);
    view_alu(2'b10, 2'b01, 3'b000, 2'b01);
    chk(K_ADR, 32'd8);
    tick();
    ResultSrc = 2'b00;
    chk(K_ADR, 32'd8);
    chk(K_WD, 32'd5);
    tick();
    ReadData = 32'hCAFE_BABE;
    tick();
    ResultSrc = 2'b01;
    chk(K_ADR, 32'hCAFE_BABE);
    tick();

    // nop with rd=x0: write 0xDEAD from Data, x0 must stay 0
    fetch(32'h0000_0013, 32'd32);
    ReadData = 32'h0000_DEAD;
    tick();
    ResultSrc = 2'b01;
    AdrSrc    = 1'b1;
    RegWrite  = 1'b1;
    chk(K_ADR, 32'h0000_DEAD);
    tick();
    RegWrite  = 1'b0;
    tick();
    view_alu(2'b10, 2'b11, 3'b000, 2'b00);
    chk(K_ADR, 32'd0);
    tick();

    // x3 = 3, then reset lands on the writeback of addi x3,x0,7
    fetch(32'h0030_0193, 32'd36);
    exec_addi(32'd3);
    fetch(32'h0070_0193, 32'd40);
    view_alu(2'b10, 2'b01, 3'b000, 2'b00);
    chk(K_ADR, 32'd7);
    tick();
    ResultSrc = 2'b00;
    RegWrite  = 1'b1;
    PCWrite   = 1'b1;
    IRWrite   = 1'b1;
    reset     = 1'b0;
    chk(K_ADR, 32'd7);
    tick();
    reset  = 1'b1;
    idle();
    AdrSrc = 1'b0;
    #1;
    checks++;
    if (Adr !== 32'h0000_0000) begin
      errors++;
      $display("FAIL Adr after mid-op reset: got %h expected %h at %0t",
               Adr, 32'h0000_0000, $time);
    end
    chk(K_ADR, 32'd0);
    chk(K_OP, 32'd0);
    chk(K_F3, 32'd0);
    chk(K_F7, 32'd0);
    chk(K_WD, 32'd0);
    tick();
    view_alu(2'b01, 2'b11, 3'b000, 2'b00);
    chk(K_ADR, 32'd0);
    tick();

    // addi x4,x3,0: read x3 back
    fetch(32'h0001_8213, 32'd0);
    view_alu(2'b10, 2'b11, 3'b000, 2'b00);
`ifdef DATAPATH_RF_RESET_EN
    chk(K_ADR, 32'd0);
`else
    chk(K_ADR, 32'd3);
`endif
    tick();

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    if (errors == 0 && checks >= 12) begin
      $display("PASS");
    end else begin
      $display("FAIL: got %0d errors expected 0", errors);
    end
    $finish;
  end

endmodule

// File: doc/multicycle_datapath.md
# multicycle_datapath

Datapath half of the multicycle RV32I core; `control_unit` is the other half. It takes the control unit's strobes and select lines and returns `op`, `funct3`, `funct7b5` and `Zero` to it. It holds the architectural and non-architectural registers (PC, OldPC, Instr, Data, A, B, ALUOut), the register file, the immediate extender and the ALU. It drives one unified instruction/data memory port.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  reset, synchronous, active-low
- `ImmSrc`  in  2  immediate format: 00 I, 01 S, 10 B, 11 J
- `ALUSrcA`  in  2  ALU operand A: 00 PC, 01 OldPC, 10 A register, 11 reserved (drives 0)
- `ALUSrcB`  in  2  ALU operand B: 00 B register, 01 ImmExt, 10 constant 4, 11 reserved (drives 0)
- `ResultSrc`  in  2  Result: 00 ALUOut, 01 Data, 10 ALUResult, 11 reserved (drives 0)
- `AdrSrc`  in  1  memory address: 0 PC, 1 Result
- `ALUControl`  in  3  000 add, 001 sub, 010 and, 011 or, 101 slt (signed); other codes give 0
- `IRWrite`  in  1  load Instr←ReadData and OldPC←PC
- `PCWrite`  in  1  load PC←Result
- `RegWrite`  in  1  write Result to rd = Instr[11:7]
- `ReadData`  in  32  memory read data, combinational from `Adr`
- `Adr`  out  32  memory address
- `WriteData`  out  32  store data (= B register)
- `op`  out  7  `opcodetype_t`, Instr[6:0]
- `funct3`  out  3  Instr[14:12]
- `funct7b5`  out  1  Instr[30]
- `Zero`  out  1  ALUResult == 0

## Operation
- Enabled registers:
  - PC updates only when `PCWrite`=1.
  - OldPC and Instr update only when `IRWrite`=1. OldPC takes the pre-edge PC.
- Free-running registers, loaded every cycle:
  - Data←ReadData
  - A←RF[Instr[19:15]], B←RF[Instr[24:20]]
  - ALUOut←ALUResult
- Register file: 32×32.
  - Two combinational read ports; x0 always reads 0.
  - One write port; writes to x0 are discarded.
- Immediate extension:
  - I: sext(Instr[31:20])
  - S: sext({Instr[31:25],Instr[11:7]})
  - B: sext({Instr[31],Instr[7],Instr[30:25],Instr[11:8],1'b0})
  - J: sext({Instr[31],Instr[19:12],Instr[20],Instr[30:21],1'b0})
- ALU:
  - add/sub wrap mod 2^32 with no flags except `Zero`.
  - slt yields 32'h1 or 32'h0 from a signed compare.
- `Zero`, `Adr` and `Result` are combinational from the current registers and selects.

## Timing
- On reset (`reset`=0 at a rising edge):
  - PC=RESET_PC; every other register goes to 0.
  - Outputs follow: `op`=0, `funct3`=0, `funct7b5`=0, `Adr`=RESET_PC when `AdrSrc`=0, `WriteData`=0.
  - Register-file contents are unchanged, except as set under Configuration.
- Reset during any state discards in-flight A/B/ALUOut/Data, and enabled writes that cycle are suppressed.
- Every enabled write takes effect at the next rising edge; the new value is visible 1 cycle later.
- Same-cycle RegWrite and read of the same register:
  - The read port returns the old value (no bypass), so A/B capture the old value.
  - The new value appears in A/B one cycle later.
- `IRWrite` and `PCWrite` asserted together (fetch): OldPC gets the old PC and PC gets Result in the same edge.
- PC is not forced aligned; any Result value is loaded.

## Configuration
- `DATAPATH_RF_RESET_EN` defined: the register-file write port clears all 32 entries on reset, and every register reads 0 after reset.
- Undefined: the register file has no reset and holds X in simulation until first written. This variant is smaller and suits FPGA LUTRAM.

## Structure
- Package `wjbot_riscv` holds:
  - `opcodetype_t`
  - enums for the ImmSrc, ALUSrcA, ALUSrcB and ResultSrc encodings
  - the ALUControl encoding constants
- `control_unit` uses the same encoding enums.
- Sub-module `regfile` (2R1W, x0 hardwired) is separate. The extender, ALU and muxes stay in this module.

## Test plan
1. **Reset:** hold `reset`=0 for 2 edges, release → PC=0, `op`=0, `Adr`=0 with `AdrSrc`=0.
2. **Fetch:**
   - Stimulus: ReadData=32'h00500093 (addi x1,x0,5); IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUControl=000, ResultSrc=10.
   - Response after edge: PC=4, OldPC=0, `op`=7'h13, `funct3`=0.
3. **addi execute and writeback:**
   - Execute: ALUSrcA=10, ALUSrcB=01, ImmSrc=00, add → ALUOut=5.
   - Writeback: ResultSrc=00, RegWrite=1 → x1=5.
   - A later instruction with rs1=x1 → A=5.
4. **Branch compare:** x1=x2=5, ALUSrcA=10, ALUSrcB=00, ALUControl=001 → `Zero`=1. Set x2=6 → `Zero`=0, ALUResult=32'hFFFF_FFFF.
5. **Store address and data:**
   - Stimulus: sw x1,8(x0) = 32'h00102423; compute ALUOut=8; set AdrSrc=1, ResultSrc=00.
   - Response: `Adr`=8, `WriteData`=5.
6. **x0 and reset mid-op:**
   - RegWrite to rd=x0 with Result=32'hDEAD → x0 still reads 0.
   - Assert reset in the writeback cycle → x-target not written, PC=RESET_PC next cycle.
